joybus_poll_sched: RTL and testbench
====================================

Name: joybus_poll_sched

Overview:
Sequences controller polling for the N64 serial path. It issues periodic poll requests to the JOYBUS host engine and supervises each one with a response timeout and bounded retries. Good samples go into a one-entry holding buffer that feeds the UART host through a valid/ready handshake. It sits in the top level between JOYBUS_host and UART_host and replaces the free-running data-ready coupling with explicit scheduling and status.

Parameters:
POLL_PERIOD, 833333, clk cycles between poll ticks (60 Hz at 50 MHz); legal range >= 4.
TIMEOUT_CYC, 50000, max cycles from jb_start to jb_done before the attempt counts as failed.
RETRY_MAX, 2, extra attempts after the first timeout; total attempts = RETRY_MAX+1.
GAP_CYC, 1000, idle cycles between a timeout and the retry's jb_start.

Ports:
clk  in  1  system clock; all logic on posedge
rst_n  in  1  asynchronous active-low reset
en  in  1  enables poll tick generation
jb_start  out  1  one-cycle pulse requesting a JOYBUS poll
jb_done  in  1  one-cycle pulse: response captured, jb_data valid this cycle
jb_data  in  32  controller response word
tx_data  out  32  buffered sample to UART_host
tx_vld  out  1  tx_data valid
tx_rdy  in  1  UART_host accepts tx_data when tx_vld & tx_rdy
poll_err  out  1  one-cycle pulse when all attempts of a poll time out
overrun  out  1  sticky: a tick arrived while a poll was still in progress
timeout_cnt  out  8  saturating count of failed polls
drop_cnt  out  8  saturating count of samples overwritten before the UART accepted them

Behaviour:
- Reset (async, rst_n low): state=IDLE; all counters 0. jb_start, tx_vld, poll_err and overrun are 0; tx_data=0; timeout_cnt=0; drop_cnt=0.
- Tick counter: counts only while en=1 and wraps at POLL_PERIOD-1. It produces a one-cycle tick on the wrap cycle, so the first tick comes POLL_PERIOD cycles after en rises. en=0 clears the counter and stops ticks. An in-flight poll still completes.
- FSM states: IDLE, ISSUE, WAIT_RESP, RETRY_GAP.
- IDLE: on tick, go to ISSUE and set attempt=0.
- ISSUE: jb_start=1 for exactly this cycle. Clear the timeout counter. Go to WAIT_RESP.
- WAIT_RESP: the timeout counter increments each cycle.
  - On jb_done, latch jb_data into the buffer and go to IDLE.
  - On timeout counter == TIMEOUT_CYC-1 without jb_done: if attempt < RETRY_MAX, increment attempt and go to RETRY_GAP. Otherwise pulse poll_err the next cycle, increment timeout_cnt (saturate at 255) and go to IDLE.
  - If jb_done and timeout expiry fall in the same cycle, jb_done wins.
  - jb_done outside WAIT_RESP is ignored.
- RETRY_GAP: wait GAP_CYC cycles, then go to ISSUE.
- A tick in any state other than IDLE sets overrun and is discarded; it is not queued. overrun clears only on reset.
- Latency: jb_start is asserted 1 cycle after the tick. tx_vld is asserted 1 cycle after jb_done.
- Buffer (one entry):
  - Load on accepted jb_done: tx_data<=jb_data and tx_vld<=1.
  - tx_vld & tx_rdy clears tx_vld; tx_data holds its value.
  - Load while tx_vld=1 and tx_rdy=0: overwrite tx_data (latest wins) and increment drop_cnt (saturate at 255).
  - Load in the same cycle as a handshake: the new data loads, tx_vld stays 1, and drop_cnt does not increment.
  - tx_data is stable while tx_vld=1 and tx_rdy=0, except for the overwrite case above.
- Counter widths: $clog2 of each parameter. TIMEOUT_CYC and GAP_CYC must be >= 2.

Decomposition:
- Shared package jb_pkg:
  - FSM state enum poll_state_t.
  - JB_WORD_W=32.
  - Default timing constants (POLL_PERIOD_60HZ, JB_TIMEOUT_DEF).
- One sub-module, jb_sample_buf: the one-entry overwrite buffer plus drop counter. Other host-side producers reuse it.
- Tick counter and FSM stay in the top module.

Test Plan:
Run all scenarios with POLL_PERIOD=20, TIMEOUT_CYC=8, RETRY_MAX=2, GAP_CYC=3.
1. Nominal poll:
   - Stimulus: en=1; jb_done 5 cycles after jb_start with jb_data=32'h8001_7F80; tx_rdy=1.
   - Response: jb_start at cycle 20. tx_vld for 1 cycle with tx_data=32'h8001_7F80. poll_err=0.
2. Retry success:
   - Stimulus: no response to the first jb_start; jb_done 2 cycles after the second jb_start.
   - Response: second jb_start 8+3+1 cycles after the first. Data delivered. timeout_cnt=0.
3. Total failure:
   - Stimulus: jb_done never asserted.
   - Response: exactly 3 jb_start pulses, then one poll_err pulse. timeout_cnt=1. FSM returns to IDLE before the next tick.
4. Back-pressure:
   - Stimulus: tx_rdy=0 across 3 successful polls with data A, B, C; then tx_rdy=1.
   - Response: drop_cnt=2. Single handshake with tx_data=C.
5. Overrun and boundary:
   - Stimulus (overrun): GAP_CYC and TIMEOUT_CYC set so a retry spans a tick.
   - Response: overrun=1, and no extra jb_start beyond the retry schedule.
   - Stimulus (boundary): jb_done coincident with the timeout-expiry cycle.
   - Response: data accepted and no retry.
6. Reset mid-op:
   - Stimulus: assert rst_n=0 during WAIT_RESP with tx_vld=1.
   - Response: all outputs 0 immediately (async). After release, the first jb_start comes POLL_PERIOD cycles later.

Source files
------------

// File: rtl/jb_pkg.sv
// Shared types and defaults for the JOYBUS poll path: state encoding, word width,
// 60 Hz timing defaults and a saturating 8-bit increment used by the status counters.
package jb_pkg;

  localparam int JB_WORD_W        = 32;
  localparam int POLL_PERIOD_60HZ = 833333;
  localparam int JB_TIMEOUT_DEF   = 50000;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RESP,
    RETRY_GAP
  } poll_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/jb_sample_buf.sv
// One-entry latest-wins sample buffer: out_vld rises 1 cycle after in_vld; a load while the
// consumer stalls overwrites the held word and bumps drop_cnt; a load never waits on out_rdy.
module jb_sample_buf
  import jb_pkg::*;
#(
  parameter int W = JB_WORD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic [W-1:0] out_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [7:0]   drop_cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_dat  <= '0;
      out_vld  <= 1'b0;
      drop_cnt <= '0;
    end else if (in_vld) begin
      out_dat <= in_dat;
      out_vld <= 1'b1;
      // a word handed over this same cycle is not lost, so only a stalled one counts
      if (out_vld && !out_rdy) drop_cnt <= sat_inc8(drop_cnt);
    end else if (out_rdy) begin
      out_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/joybus_poll_sched.sv
// Periodic JOYBUS poll scheduler with timeout/retry supervision; jb_start 1 cycle after a tick,
// tx_vld 1 cycle after jb_done. The UART side never stalls polling: the buffer overwrites instead.
module joybus_poll_sched
  import jb_pkg::*;
#(
  parameter int POLL_PERIOD = POLL_PERIOD_60HZ,
  parameter int TIMEOUT_CYC = JB_TIMEOUT_DEF,
  parameter int RETRY_MAX   = 2,
  parameter int GAP_CYC     = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  output logic                 jb_start,
  input  logic                 jb_done,
  input  logic [JB_WORD_W-1:0] jb_data,
  output logic [JB_WORD_W-1:0] tx_data,
  output logic                 tx_vld,
  input  logic                 tx_rdy,
  output logic                 poll_err,
  output logic                 overrun,
  output logic [7:0]           timeout_cnt,
  output logic [7:0]           drop_cnt
);

  localparam int PW = $clog2(POLL_PERIOD);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam int GW = $clog2(GAP_CYC);
  localparam int AW = $clog2(RETRY_MAX + 2);

  localparam logic [PW-1:0] TICK_LAST  = PW'(POLL_PERIOD - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYC - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYC - 1);
  localparam logic [AW-1:0] RETRY_LAST = AW'(RETRY_MAX);

  logic [PW-1:0] tick_cnt;
  logic          tick;
  poll_state_t   state;
  logic [TW-1:0] to_cnt;
  logic [GW-1:0] gap_cnt;
  logic [AW-1:0] attempt;
  logic          accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (!en || tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + PW'(1);
    end
  end

  assign tick   = en && (tick_cnt == TICK_LAST);
  // a response only counts while an attempt is actually waiting for one
  assign accept = (state == WAIT_RESP) && jb_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      to_cnt      <= '0;
      gap_cnt     <= '0;
      attempt     <= '0;
      jb_start    <= 1'b0;
      poll_err    <= 1'b0;
      overrun     <= 1'b0;
      timeout_cnt <= '0;
    end else begin
      jb_start <= 1'b0;
      poll_err <= 1'b0;
      if (tick && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (tick) begin
            state    <= ISSUE;
            attempt  <= '0;
            jb_start <= 1'b1;
          end
        end
        ISSUE: begin
          to_cnt <= '0;
          state  <= WAIT_RESP;
        end
        WAIT_RESP: begin
          if (jb_done) begin
            state <= IDLE;
          end else if (to_cnt == TO_LAST) begin
            if (attempt < RETRY_LAST) begin
              attempt <= attempt + AW'(1);
              gap_cnt <= '0;
              state   <= RETRY_GAP;
            end else begin
              poll_err    <= 1'b1;
              timeout_cnt <= sat_inc8(timeout_cnt);
              state       <= IDLE;
            end
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        RETRY_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state    <= ISSUE;
            jb_start <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  jb_sample_buf #(
    .W(JB_WORD_W)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (accept),
    .in_dat   (jb_data),
    .out_dat  (tx_data),
    .out_vld  (tx_vld),
    .out_rdy  (tx_rdy),
    .drop_cnt (drop_cnt)
  );

endmodule

// File: tb/tb_joybus_poll_sched.sv
// Bench for joybus_poll_sched: table of single-poll scenarios, hand-written corner sequences,
// then a long random run against a schedule/interval model of the expected outputs.
module tb_joybus_poll_sched;

  localparam int P  = 20;
  localparam int TO = 8;
  localparam int R  = 2;
  localparam int G  = 3;
  localparam int N  = 2000;
  localparam int NR = 512;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        jb_start;
  logic        jb_done = 1'b0;
  logic [31:0] jb_data = '0;
  logic [31:0] tx_data;
  logic        tx_vld;
  logic        tx_rdy = 1'b0;
  logic        poll_err;
  logic        overrun;
  logic [7:0]  timeout_cnt;
  logic [7:0]  drop_cnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int          plan_d[$];
  logic [31:0] plan_dat[$];
  int          due = -1;
  logic [31:0] due_dat = '0;

  typedef struct {
    int          d0, d1, d2;
    logic [31:0] dat;
    int          n, err, tx, att;
  } row_t;
  row_t rows[7];

  int          rd[NR];
  logic [31:0] rdat[NR];
  bit          rdy_pat[N];
  bit          exp_js[N], exp_err[N], exp_vld[N], exp_ovr[N];
  logic [31:0] exp_dat[N];
  int          exp_tout[N], exp_drop[N];

  joybus_poll_sched #(
    .POLL_PERIOD(P), .TIMEOUT_CYC(TO), .RETRY_MAX(R), .GAP_CYC(G)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .jb_start(jb_start), .jb_done(jb_done),
    .jb_data(jb_data), .tx_data(tx_data), .tx_vld(tx_vld), .tx_rdy(tx_rdy),
    .poll_err(poll_err), .overrun(overrun), .timeout_cnt(timeout_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Advance to the next falling edge and play the JOYBUS device: each jb_start consumes
  // one planned (delay, data) pair; delay 0 means the device stays silent.
  task automatic next_cycle();
    int d;
    @(negedge clk);
    jb_done = 1'b0;
    jb_data = $urandom();
    if (rst_n && jb_start) begin
      due = -1;
      if (plan_d.size() > 0) begin
        d = plan_d.pop_front();
        due_dat = plan_dat.pop_front();
        if (d > 0) due = cyc + d;
      end
    end
    if (due == cyc) begin
      jb_done = 1'b1;
      jb_data = due_dat;
      due = -1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0;
    tx_rdy = 1'b0;
    plan_d.delete();
    plan_dat.delete();
    due = -1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic run_row(input int idx);
    int n_st, st0, prev, n_err, err_at, tx_at, n_vld;
    logic [31:0] txd;
    do_reset();
    plan_d.push_back(rows[idx].d0); plan_dat.push_back(rows[idx].dat);
    plan_d.push_back(rows[idx].d1); plan_dat.push_back(rows[idx].dat + 32'd1);
    plan_d.push_back(rows[idx].d2); plan_dat.push_back(rows[idx].dat + 32'd2);
    en = 1'b1;
    tx_rdy = 1'b1;
    n_st = 0; st0 = -1; prev = 0; n_err = 0; err_at = -1; tx_at = -1; n_vld = 0; txd = '0;
    for (int r = 1; r <= 80; r++) begin
      next_cycle();
      if (jb_start) begin
        if (n_st == 0) begin
          st0 = r;
          en = 1'b0;
        end else begin
          chk($sformatf("row%0d_retry_spacing", idx), r - prev, 1 + TO + G);
        end
        prev = r;
        n_st++;
      end
      if (poll_err) begin
        n_err++;
        err_at = r - st0;
      end
      if (tx_vld) begin
        n_vld++;
        tx_at = r - st0;
        txd = tx_data;
      end
    end
    chk($sformatf("row%0d_first_start", idx), st0, P);
    chk($sformatf("row%0d_n_starts", idx), n_st, rows[idx].n);
    chk($sformatf("row%0d_n_poll_err", idx), n_err, (rows[idx].err >= 0) ? 1 : 0);
    chk($sformatf("row%0d_poll_err_at", idx), err_at, rows[idx].err);
    chk($sformatf("row%0d_tx_vld_at", idx), tx_at, rows[idx].tx);
    chk($sformatf("row%0d_tx_vld_cycles", idx), n_vld, (rows[idx].tx >= 0) ? 1 : 0);
    chk($sformatf("row%0d_tx_data", idx), txd,
        (rows[idx].tx >= 0) ? rows[idx].dat + rows[idx].att : 32'd0);
    chk($sformatf("row%0d_timeout_cnt", idx), timeout_cnt, (rows[idx].err >= 0) ? 1 : 0);
    chk($sformatf("row%0d_drop_cnt", idx), drop_cnt, 0);
    chk($sformatf("row%0d_overrun", idx), overrun, 0);
  endtask

  // Expected outputs from the poll rules: ticks every P cycles, each poll's attempts
  // spaced 1+TO+G apart, and each sample visible until taken or replaced.
  task automatic build_model();
    int busy_end, ri, tk, s, dd, first_ovr, w0, w1, hs, tcnt, dcnt, nl;
    int ld_at[$];
    logic [31:0] ld_dat[$];
    int drop_inc[N];
    busy_end = 0; ri = 0; first_ovr = N;
    for (int c = 0; c < N; c++) begin
      exp_js[c] = 0; exp_err[c] = 0; exp_vld[c] = 0; exp_dat[c] = '0; drop_inc[c] = 0;
    end
    for (int k = 1; k * P - 1 < N; k++) begin
      tk = k * P - 1;
      if (tk < busy_end) begin
        if (first_ovr == N) first_ovr = tk + 1;
      end else begin
        s = tk + 1;
        for (int a = 0; a <= R; a++) begin
          dd = rd[ri];
          ri++;
          if (s < N) exp_js[s] = 1;
          if (dd >= 1 && dd <= TO) begin
            ld_at.push_back(s + dd);
            ld_dat.push_back(rdat[ri-1]);
            busy_end = s + dd + 1;
            break;
          end
          if (a < R) begin
            s = s + 1 + TO + G;
          end else begin
            if (s + TO + 1 < N) exp_err[s + TO + 1] = 1;
            busy_end = s + TO + 1;
          end
        end
      end
    end
    nl = ld_at.size();
    for (int i = 0; i < nl; i++) begin
      w0 = ld_at[i] + 1;
      w1 = (i + 1 < nl) ? ld_at[i+1] : N - 1;
      hs = -1;
      for (int c = w0; c <= w1 && c < N; c++) begin
        exp_dat[c] = ld_dat[i];
        if (hs < 0) begin
          exp_vld[c] = 1;
          if (rdy_pat[c]) hs = c;
        end
      end
      if (hs < 0 && i + 1 < nl && ld_at[i+1] + 1 < N) drop_inc[ld_at[i+1] + 1]++;
    end
    tcnt = 0; dcnt = 0;
    for (int c = 0; c < N; c++) begin
      if (exp_err[c]) tcnt = (tcnt < 255) ? tcnt + 1 : 255;
      dcnt = (dcnt + drop_inc[c] > 255) ? 255 : dcnt + drop_inc[c];
      exp_tout[c] = tcnt;
      exp_drop[c] = dcnt;
      exp_ovr[c]  = (c >= first_ovr);
    end
  endtask

  initial begin
    int n_st, n_hs, err_r, first, k;
    int st[$];
    logic [31:0] hs_dat;
    bit seg_off[N/64 + 1];

    rows[0] = '{5, 0, 0, 32'h8001_7F80, 1, -1,  6, 0};
    rows[1] = '{0, 2, 0, 32'hA5A5_0010, 2, -1, 15, 1};
    rows[2] = '{0, 0, 0, 32'h1234_5670, 3, 33, -1, 0};
    rows[3] = '{8, 0, 0, 32'hB00D_0000, 1, -1,  9, 0};
    rows[4] = '{9, 1, 0, 32'hC0DE_0100, 2, -1, 14, 1};
    rows[5] = '{0, 0, 8, 32'hD1CE_0200, 3, -1, 33, 2};
    rows[6] = '{1, 0, 0, 32'h0F0F_0300, 1, -1,  2, 0};

    @(negedge clk);
    chk("rst_jb_start", jb_start, 0);
    chk("rst_tx_vld", tx_vld, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_poll_err", poll_err, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_timeout_cnt", timeout_cnt, 0);
    chk("rst_drop_cnt", drop_cnt, 0);

    for (int i = 0; i < 7; i++) run_row(i);

    // back-pressure: three samples while the UART stalls, then a single handshake
    do_reset();
    plan_d.push_back(2); plan_dat.push_back(32'hAAAA_0001);
    plan_d.push_back(2); plan_dat.push_back(32'hBBBB_0002);
    plan_d.push_back(2); plan_dat.push_back(32'hCCCC_0003);
    en = 1'b1;
    n_st = 0;
    for (int r = 1; r <= 70; r++) begin
      next_cycle();
      if (jb_start) begin
        n_st++;
        if (n_st == 3) en = 1'b0;
      end
    end
    chk("bp_n_starts", n_st, 3);
    chk("bp_drop_cnt", drop_cnt, 2);
    chk("bp_tx_vld_held", tx_vld, 1);
    chk("bp_tx_data_latest", tx_data, 32'hCCCC_0003);
    tx_rdy = 1'b1;
    n_hs = tx_vld ? 1 : 0;
    hs_dat = tx_data;
    repeat (4) begin
      next_cycle();
      if (tx_vld) n_hs++;
    end
    chk("bp_n_handshakes", n_hs, 1);
    chk("bp_hs_data", hs_dat, 32'hCCCC_0003);
    chk("bp_drop_cnt_after", drop_cnt, 2);

    // overrun: a failing poll's retries span the next tick
    do_reset();
    plan_d = '{0, 0, 0, 3};
    plan_dat = '{32'h1, 32'h2, 32'h3, 32'hDDDD_0004};
    en = 1'b1;
    tx_rdy = 1'b1;
    st.delete();
    err_r = -1;
    for (int r = 1; r <= 70; r++) begin
      next_cycle();
      if (jb_start) st.push_back(r);
      if (poll_err) err_r = r;
      if (r == 39) chk("ovr_before_tick", overrun, 0);
      if (r == 40) chk("ovr_after_tick", overrun, 1);
    end
    chk("ovr_n_starts", st.size(), 4);
    for (int i = 0; i < st.size() && i < 4; i++)
      chk($sformatf("ovr_start%0d", i), st[i], (i < 3) ? 20 + 12 * i : 60);
    chk("ovr_poll_err_at", err_r, 53);
    chk("ovr_timeout_cnt", timeout_cnt, 1);
    chk("ovr_sticky", overrun, 1);
    chk("ovr_tx_data", tx_data, 32'hDDDD_0004);

    // reset while waiting for a response with a sample still pending
    do_reset();
    plan_d = '{2, 0, 0, 0};
    plan_dat = '{32'hEEEE_0005, 32'h0, 32'h0, 32'h0};
    en = 1'b1;
    for (int r = 1; r <= 43; r++) next_cycle();
    chk("mid_tx_vld_before", tx_vld, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_jb_start", jb_start, 0);
    chk("mid_tx_vld", tx_vld, 0);
    chk("mid_tx_data", tx_data, 0);
    chk("mid_poll_err", poll_err, 0);
    chk("mid_overrun", overrun, 0);
    chk("mid_timeout_cnt", timeout_cnt, 0);
    chk("mid_drop_cnt", drop_cnt, 0);
    plan_d.delete();
    plan_dat.delete();
    due = -1;
    @(negedge clk);
    rst_n = 1'b1;
    first = -1;
    for (int r = 1; r <= 25; r++) begin
      next_cycle();
      if (jb_start && first < 0) first = r;
    end
    chk("mid_first_start_after_rst", first, P);

    // random run against the model
    do_reset();
    for (int i = 0; i < NR; i++) begin
      k = $urandom_range(0, 9);
      if (k < 5)      rd[i] = $urandom_range(1, TO);
      else if (k < 8) rd[i] = 0;
      else            rd[i] = $urandom_range(TO + 1, TO + 2);
      rdat[i] = $urandom();
      plan_d.push_back(rd[i]);
      plan_dat.push_back(rdat[i]);
    end
    for (int s = 0; s <= N / 64; s++) seg_off[s] = ($urandom_range(0, 2) == 0);
    for (int c = 0; c < N; c++) rdy_pat[c] = !seg_off[c / 64] && ($urandom_range(0, 3) != 0);
    build_model();
    en = 1'b1;
    tx_rdy = rdy_pat[0];
    for (int r = 1; r < N; r++) begin
      next_cycle();
      chk($sformatf("rnd_jb_start@%0d", r), jb_start, exp_js[r]);
      chk($sformatf("rnd_poll_err@%0d", r), poll_err, exp_err[r]);
      chk($sformatf("rnd_tx_vld@%0d", r), tx_vld, exp_vld[r]);
      chk($sformatf("rnd_tx_data@%0d", r), tx_data, exp_dat[r]);
      chk($sformatf("rnd_timeout_cnt@%0d", r), timeout_cnt, exp_tout[r]);
      chk($sformatf("rnd_drop_cnt@%0d", r), drop_cnt, exp_drop[r]);
      chk($sformatf("rnd_overrun@%0d", r), overrun, exp_ovr[r]);
      tx_rdy = rdy_pat[r];
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
